// File: rtl/uart_rx_if.sv
// Serial-line / received-data bundle shared by the UART receiver and its environment.
interface uart_rx_if;
    logic       rx;            // serial line, idle high, asynchronous to clk
    logic       s_tick;        // 16x baud oversample enable, one clk wide
    logic [7:0] dout;          // received data, right-aligned
    logic       rx_done_tick;  // one-clk frame-complete pulse
    logic       frame_err;     // stop-bit status of the last completed frame

    // Line driver / data consumer side
    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, DBIT data bits, one stop bit
// checked over SB_TICK ticks. Start bit is re-checked at its mid-point so
// short glitches on the idle line are rejected.
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16   // s_tick periods spent in the stop bit, 1..16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    logic       r_sync1;
    logic       r_rx_s;
    logic [1:0] r_state;
    logic [3:0] r_s;
    logic [2:0] r_n;
    logic [7:0] r_b;
    logic       r_frame_err;

    logic [1:0] w_state_next;
    logic [3:0] w_s_next;
    logic [2:0] w_n_next;
    logic [7:0] w_b_next;
    logic       w_done;
    logic [7:0] w_dout;

    // Two-flop synchronizer; flops reset to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Next-state logic; everything except idle->start waits for s_tick
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_s_next     = 4'd0;
                end
            end
            ST_START: begin
                if (bus.s_tick) begin
                    if (r_s == 4'd7) begin
                        // Mid-point of the start bit: still low means a real frame
                        if (!r_rx_s) begin
                            w_state_next = ST_DATA;
                            w_s_next     = 4'd0;
                            w_n_next     = 3'd0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.s_tick) begin
                    if (r_s == 4'd15) begin
                        w_s_next = 4'd0;
                        w_b_next = {r_rx_s, r_b[7:1]};
                        if (r_n == N_LAST) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.s_tick) begin
                    if (r_s == SB_LAST) begin
                        w_state_next = ST_IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= 4'd0;
            r_n     <= 3'd0;
            r_b     <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
        end
    end

    // Latch the stop-bit level when a frame completes; low stop bit is an error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else if (w_done) begin
            r_frame_err <= ~r_rx_s;
        end
    end

    // Short frames leave data in the top of the shift register; right-align it
    for (genvar gi = 0; gi < 8; gi++) begin : g_dout
        if (gi < DBIT) begin : g_bit
            assign w_dout[gi] = r_b[gi + 8 - DBIT];
        end else begin : g_zero
            assign w_dout[gi] = 1'b0;
        end
    end

    assign bus.dout         = w_dout;
    assign bus.rx_done_tick = w_done;
    assign bus.frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: DBIT=8 and DBIT=7 instances on a shared line.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int TICKW = 4;  // clk cycles per s_tick period

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic rx_line   = 1'b1;
    logic tick_line = 1'b0;

    int tick_idx = 0;
    int total    = 0;
    int bad      = 0;
    int done8    = 0;
    int done7    = 0;
    int done_at8 = -1;
    int done_at7 = -1;

    uart_rx_if if8();
    uart_rx_if if7();

    assign if8.rx     = rx_line;
    assign if8.s_tick = tick_line;
    assign if7.rx     = rx_line;
    assign if7.s_tick = tick_line;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (
        .clk   (clk),
        .reset (reset),
        .bus   (if7.slave)
    );

    always #5 clk = ~clk;

    // Count completion pulses mid-cycle and note which s_tick they fell on
    always @(negedge clk) begin
        if (if8.rx_done_tick === 1'b1) begin
            done8    <= done8 + 1;
            done_at8 <= tick_idx;
        end
        if (if7.rx_done_tick === 1'b1) begin
            done7    <= done7 + 1;
            done_at7 <= tick_idx;
        end
    end

    // One clk cycle; inputs change 2 ns after the rising edge
    task automatic clk_step(input logic tick);
        @(posedge clk);
        #2;
        tick_line = tick;
        if (tick) tick_idx++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            clk_step(1'b1);
            repeat (TICKW - 1) clk_step(1'b0);
        end
    endtask

    // Falling edge plus two tick-free cycles so start is detected before tick 1
    task automatic start_edge();
        clk_step(1'b0);
        rx_line  = 1'b0;
        tick_idx = 0;
        clk_step(1'b0);
        clk_step(1'b0);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_val);
        start_edge();
        tick_n(16);
        for (int i = 0; i < nbits; i++) begin
            rx_line = data[i];
            tick_n(16);
        end
        rx_line = stop_val;
        tick_n(8);
        rx_line = 1'b1;
        tick_n(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) clk_step(1'b0);
        total++; if (if8.dout !== 8'h00) begin bad++; $display("FAIL reset_dout8 got=%h exp=00", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr8 got=%b exp=0", if8.frame_err); end
        total++; if (if8.rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", if8.rx_done_tick); end
        total++; if (if7.dout !== 8'h00) begin bad++; $display("FAIL reset_dout7 got=%h exp=00", if7.dout); end
        total++; if (if7.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr7 got=%b exp=0", if7.frame_err); end
        reset = 1'b0;
        tick_n(4);
        total++; if (done8 !== 0) begin bad++; $display("FAIL idle_no_done got=%0d exp=0", done8); end
        $display("reset: dout8=%h ferr8=%b", if8.dout, if8.frame_err);
    endtask

    task automatic test_frame_a5();
        int d0;
        d0 = done8;
        send_frame(8'hA5, 8, 1'b1);
        total++; if (done8 - d0 !== 1) begin bad++; $display("FAIL a5_done_count got=%0d exp=1", done8 - d0); end
        total++; if (if8.dout !== 8'hA5) begin bad++; $display("FAIL a5_dout got=%h exp=a5", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL a5_ferr got=%b exp=0", if8.frame_err); end
        total++; if (done_at8 !== 152) begin bad++; $display("FAIL a5_latency got=%0d exp=152", done_at8); end
        $display("frame a5: dout=%h ferr=%b done_at=%0d", if8.dout, if8.frame_err, done_at8);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done8;
        send_frame(8'h00, 8, 1'b1);
        total++; if (done8 - d0 !== 1) begin bad++; $display("FAIL b2b0_done_count got=%0d exp=1", done8 - d0); end
        total++; if (if8.dout !== 8'h00) begin bad++; $display("FAIL b2b0_dout got=%h exp=00", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL b2b0_ferr got=%b exp=0", if8.frame_err); end
        $display("frame 00: dout=%h ferr=%b", if8.dout, if8.frame_err);
        send_frame(8'hFF, 8, 1'b1);
        total++; if (done8 - d0 !== 2) begin bad++; $display("FAIL b2b1_done_count got=%0d exp=2", done8 - d0); end
        total++; if (if8.dout !== 8'hFF) begin bad++; $display("FAIL b2b1_dout got=%h exp=ff", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL b2b1_ferr got=%b exp=0", if8.frame_err); end
        $display("frame ff: dout=%h ferr=%b", if8.dout, if8.frame_err);
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done8;
        start_edge();
        tick_n(4);
        rx_line = 1'b1;
        tick_n(12);
        total++; if (done8 - d0 !== 0) begin bad++; $display("FAIL glitch_done_count got=%0d exp=0", done8 - d0); end
        total++; if (if8.dout !== 8'hFF) begin bad++; $display("FAIL glitch_dout got=%h exp=ff", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b exp=0", if8.frame_err); end
        $display("glitch: dout=%h ferr=%b", if8.dout, if8.frame_err);
    endtask

    task automatic test_frame_err();
        int d0;
        d0 = done8;
        send_frame(8'h3C, 8, 1'b0);
        total++; if (done8 - d0 !== 1) begin bad++; $display("FAIL ferr_done_count got=%0d exp=1", done8 - d0); end
        total++; if (if8.dout !== 8'h3C) begin bad++; $display("FAIL ferr_dout got=%h exp=3c", if8.dout); end
        total++; if (if8.frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", if8.frame_err); end
        $display("frame 3c bad stop: dout=%h ferr=%b", if8.dout, if8.frame_err);
        tick_n(2);
        send_frame(8'h81, 8, 1'b1);
        total++; if (done8 - d0 !== 2) begin bad++; $display("FAIL ferr_next_count got=%0d exp=2", done8 - d0); end
        total++; if (if8.dout !== 8'h81) begin bad++; $display("FAIL ferr_next_dout got=%h exp=81", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", if8.frame_err); end
        $display("frame 81: dout=%h ferr=%b", if8.dout, if8.frame_err);
    endtask

    task automatic test_reset_midframe();
        int d0;
        logic [7:0] pat;
        pat = 8'hC3;
        send_frame(8'h99, 8, 1'b0);
        total++; if (if8.frame_err !== 1'b1) begin bad++; $display("FAIL mid_pre_ferr got=%b exp=1", if8.frame_err); end
        tick_n(2);
        start_edge();
        tick_n(16);
        for (int i = 0; i < 4; i++) begin
            rx_line = pat[i];
            tick_n(16);
        end
        rx_line = pat[4];
        tick_n(5);
        // 0x99 shifted right by four with bits 1,1,0,0 entering at the top
        total++; if (if8.dout !== 8'h39) begin bad++; $display("FAIL mid_pre_dout got=%h exp=39", if8.dout); end
        d0 = done8;
        #1 reset = 1'b1;
        #1;
        total++; if (if8.dout !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%h exp=00", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_ferr got=%b exp=0", if8.frame_err); end
        total++; if (if8.rx_done_tick !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", if8.rx_done_tick); end
        $display("reset mid-frame: dout=%h ferr=%b", if8.dout, if8.frame_err);
        rx_line = 1'b1;
        repeat (3) clk_step(1'b0);
        reset = 1'b0;
        tick_n(4);
        send_frame(8'h5A, 8, 1'b1);
        total++; if (done8 - d0 !== 1) begin bad++; $display("FAIL mid_after_count got=%0d exp=1", done8 - d0); end
        total++; if (if8.dout !== 8'h5A) begin bad++; $display("FAIL mid_after_dout got=%h exp=5a", if8.dout); end
        total++; if (if8.frame_err !== 1'b0) begin bad++; $display("FAIL mid_after_ferr got=%b exp=0", if8.frame_err); end
        total++; if (done_at8 !== 152) begin bad++; $display("FAIL mid_after_latency got=%0d exp=152", done_at8); end
        $display("frame 5a: dout=%h ferr=%b done_at=%0d", if8.dout, if8.frame_err, done_at8);
    endtask

    task automatic test_dbit7();
        int d0;
        logic [7:0] got;
        clk_step(1'b0);
        reset = 1'b1;
        clk_step(1'b0);
        reset = 1'b0;
        tick_n(2);
        d0 = done7;
        send_frame(8'h55, 7, 1'b1);
        got = if7.dout;
        total++; if (done7 - d0 !== 1) begin bad++; $display("FAIL d7_done_count got=%0d exp=1", done7 - d0); end
        total++; if (got !== 8'h55) begin bad++; $display("FAIL d7_dout got=%h exp=55", got); end
        total++; if (got[7] !== 1'b0) begin bad++; $display("FAIL d7_bit7 got=%b exp=0", got[7]); end
        total++; if (done_at7 !== 136) begin bad++; $display("FAIL d7_latency got=%0d exp=136", done_at7); end
        total++; if (if7.frame_err !== 1'b0) begin bad++; $display("FAIL d7_ferr got=%b exp=0", if7.frame_err); end
        $display("dbit7 frame 55: dout=%h ferr=%b done_at=%0d", got, if7.frame_err, done_at7);
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_dbit7();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
